// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic             div_by_zero_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, flush_i,
        input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, flush_i,
        output busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_mag;
    logic               prod_neg;
    logic               quo_neg;
    logic               rem_neg;
    logic               dbz;
    logic               is_div;

    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               last_iter;

    always_comb begin
        sign1 = bus.op_i[0] & bus.data1_i[WIDTH-1];
        sign2 = bus.op_i[0] & bus.data2_i[WIDTH-1];
        mag1  = sign1 ? -bus.data1_i : bus.data1_i;
        mag2  = sign2 ? -bus.data2_i : bus.data2_i;
        last_iter = (cnt == CNT_W'(WIDTH - 1));

        // acc holds {partial product, remaining multiplier bits}; the add carries into bit WIDTH
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // acc holds {partial remainder, dividend bits shifting into quotient bits}
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        acc_neg = -acc;
        fix_hi  = acc[2*WIDTH-1:WIDTH];
        fix_lo  = acc[WIDTH-1:0];
        if (dbz) begin
            fix_hi = acc[2*WIDTH-1:WIDTH];
            fix_lo = acc[WIDTH-1:0];
        end else if (is_div) begin
            fix_hi = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = quo_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end else if (prod_neg) begin
            fix_hi = acc_neg[2*WIDTH-1:WIDTH];
            fix_lo = acc_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state             <= IDLE;
            cnt               <= '0;
            acc               <= '0;
            b_mag             <= '0;
            prod_neg          <= 1'b0;
            quo_neg           <= 1'b0;
            rem_neg           <= 1'b0;
            dbz               <= 1'b0;
            is_div            <= 1'b0;
            bus.busy_o        <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.div_by_zero_o <= 1'b0;
            bus.hi_o          <= '0;
            bus.lo_o          <= '0;
        end else begin
            bus.done_o        <= 1'b0;
            bus.div_by_zero_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        cnt        <= '0;
                        prod_neg   <= sign1 ^ sign2;
                        quo_neg    <= sign1 ^ sign2;
                        rem_neg    <= sign1;
                        is_div     <= bus.op_i[1];
                        dbz        <= 1'b0;
                        b_mag      <= mag2;
                        bus.busy_o <= 1'b1;
                        if (!bus.op_i[1]) begin
                            acc   <= {{WIDTH{1'b0}}, mag2};
                            b_mag <= mag1;
                            state <= MUL;
                        end else if (bus.data2_i != '0) begin
                            acc   <= {{WIDTH{1'b0}}, mag1};
                            state <= DIV;
                        end else begin
                            // preload the architectural div-by-zero result so FIX just copies it out
                            acc   <= {bus.data1_i, {WIDTH{1'b1}}};
                            dbz   <= 1'b1;
                            state <= FIX;
                        end
                    end
                end
                MUL, DIV: begin
                    if (bus.flush_i) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                    end else begin
                        acc <= (state == MUL) ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                        if (last_iter) state <= FIX;
                    end
                end
                FIX: begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                    if (!bus.flush_i) begin
                        bus.hi_o          <= fix_hi;
                        bus.lo_o          <= fix_lo;
                        bus.done_o        <= 1'b1;
                        bus.div_by_zero_o <= dbz;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
